// File: rtl/decode_regfile_if.sv
// Bundles the fetch, execute and writeback signals of the decode/operand-read stage.
// The slave modport is the decode stage's view; the master modport is its environment's view.
interface decode_regfile_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        ex_enable;
  logic [5:0]  ex_opecode;
  logic [4:0]  ex_rd_no;
  logic [4:0]  ex_rs_no;
  logic [4:0]  ex_rt_no;
  logic [15:0] ex_offset;
  logic [31:0] ex_pc;
  logic        ex_fmode1;
  logic        ex_fmode2;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_stop;
  logic        ex_flush;

  logic        wb_enable;
  logic        wb_fmode;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  modport slave (
    input  in_valid, in_instr, in_pc, ex_stop, ex_flush,
           wb_enable, wb_fmode, wb_reg, wb_data,
    output in_ready, ex_enable, ex_opecode, ex_rd_no, ex_rs_no, ex_rt_no,
           ex_offset, ex_pc, ex_fmode1, ex_fmode2, ex_rs, ex_rt
  );

  modport master (
    output in_valid, in_instr, in_pc, ex_stop, ex_flush,
           wb_enable, wb_fmode, wb_reg, wb_data,
    input  in_ready, ex_enable, ex_opecode, ex_rd_no, ex_rs_no, ex_rt_no,
           ex_offset, ex_pc, ex_fmode1, ex_fmode2, ex_rs, ex_rt
  );
endinterface

// File: rtl/decode_regfile.sv
// Decode/operand-read stage: one-entry holding register, integer and float register files.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data to the operands.
module decode_regfile #(
  parameter logic [31:0] RESET_SP = 32'h0007_fffc,
  parameter logic [31:0] RESET_HP = 32'h0004_0000
) (
  input logic             clk,
  input logic             rstn,
  decode_regfile_if.slave bus
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] int_rf_q [32];
  logic [31:0] int_rf_d [32];
  logic [31:0] fp_rf_q  [32];
  logic [31:0] fp_rf_d  [32];

  logic full, consume, accept;

  assign full          = (state_q == ST_FULL);
  assign bus.ex_enable = full & ~bus.ex_flush;
  assign consume       = bus.ex_enable & ~bus.ex_stop;
  assign bus.in_ready  = ~full | consume;
  // A flush beats a simultaneous fetch even when in_ready reads 1.
  assign accept        = bus.in_valid & bus.in_ready & ~bus.ex_flush;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          instr_d = bus.in_instr;
          pc_d    = bus.in_pc;
        end
      end
      ST_FULL: begin
        if (bus.ex_flush) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          instr_d = bus.in_instr;
          pc_d    = bus.in_pc;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  always_comb begin
    int_rf_d = int_rf_q;
    fp_rf_d  = fp_rf_q;
    if (bus.wb_enable) begin
      if (bus.wb_fmode) begin
        fp_rf_d[bus.wb_reg] = bus.wb_data;
      end else if (bus.wb_reg != 5'd0) begin
        int_rf_d[bus.wb_reg] = bus.wb_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: the register files are reset because software relies on sp/hp and zeroed registers;
  // memories without a defined reset value would normally be left unreset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        int_rf_q[i] <= (i == 29) ? RESET_SP : (i == 30) ? RESET_HP : 32'd0;
        fp_rf_q[i]  <= 32'd0;
      end
    end else begin
      int_rf_q <= int_rf_d;
      fp_rf_q  <= fp_rf_d;
    end
  end

  function automatic logic [31:0] read_operand(input logic fmode, input logic [4:0] num);
    logic [31:0] val;
    val = fmode ? fp_rf_q[num] : int_rf_q[num];
`ifdef DECODE_BYPASS_EN
    if (bus.wb_enable && (bus.wb_fmode == fmode) && (bus.wb_reg == num)) begin
      val = bus.wb_data;
    end
`endif
    if (!fmode && (num == 5'd0)) begin
      val = 32'd0;
    end
    return val;
  endfunction

  assign bus.ex_opecode = instr_q[31:26];
  assign bus.ex_rd_no   = instr_q[25:21];
  assign bus.ex_rs_no   = instr_q[20:16];
  assign bus.ex_rt_no   = instr_q[15:11];
  assign bus.ex_offset  = instr_q[15:0];
  assign bus.ex_pc      = pc_q;
  assign bus.ex_fmode1  = instr_q[30];
  assign bus.ex_fmode2  = instr_q[31];

  // Operands are re-read every cycle so writebacks landing during a stall become visible.
  always_comb begin
    bus.ex_rs = read_operand(instr_q[30], instr_q[20:16]);
    bus.ex_rt = read_operand(instr_q[31], instr_q[15:11]);
  end

endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Decode/operand-read stage directly upstream of the execute stage.
- Accepts instruction words from fetch, splits them into opecode/register/offset fields, and reads the integer and float register files (32x32 each).
- Presents one instruction per cycle to execute. Holds and re-presents it while execute signals stop; drops it on a branch redirect.
- Owns both register files and absorbs execute's writeback port.

Parameters:
- RESET_SP, 32'h0007_fffc, reset value of integer register 29 (stack pointer); all other registers reset to 0.
- RESET_HP, 32'h0004_0000, reset value of integer register 30 (heap pointer).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  this stage accepts in this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  address of in_instr
- ex_enable  out  1  valid instruction presented to execute
- ex_opecode  out  6  instr[31:26]
- ex_rd_no  out  5  instr[25:21]
- ex_rs_no  out  5  instr[20:16]
- ex_rt_no  out  5  instr[15:11]
- ex_offset  out  16  instr[15:0]
- ex_pc  out  32  pc of held instruction
- ex_fmode1  out  1  rs file select = opecode[4] (1 = float)
- ex_fmode2  out  1  rt file select = opecode[5] (1 = float)
- ex_rs  out  32  rs operand
- ex_rt  out  32  rt operand
- ex_stop  in  1  execute did not consume the presented instruction
- ex_flush  in  1  execute redirected the pc (pcenable)
- wb_enable  in  1  writeback strobe
- wb_fmode  in  1  1 = float file
- wb_reg  in  5  destination register
- wb_data  in  32  write data

Behaviour:
- Reset (async, rstn low): full=0, held instr=0, held pc=0. Registers per parameters. Outputs: ex_enable=0, in_ready=1, fields 0. Reset mid-operation discards the held instruction.
- States: EMPTY (full=0), FULL (full=1, instr/pc registers valid).
- ex_enable = full & ~ex_flush.
- consume = ex_enable & ~ex_stop.
- in_ready = ~full | consume.
- Accept when in_valid & in_ready & ~ex_flush. Latch instr and pc; full stays or becomes 1. Latency is 1 cycle: accepted at edge N, presented during cycle N+1.
- consume without accept: full to 0.
- ex_stop with full: hold instr/pc unchanged and re-present next cycle, indefinitely.
- ex_flush: full to 0 at next edge. A simultaneous in_valid is dropped (not accepted; in_ready may read 1 but the flush wins). Fetch re-fetches from the new pc.
- Operand read is combinational from the held fields each cycle, so writebacks landing while the instruction is held are visible. rs reads file ex_fmode1 at rs_no; rt reads file ex_fmode2 at rt_no.
- Integer r0 reads 0 always; writes to integer r0 are ignored. Float f0 is an ordinary register.
- Write: on wb_enable at the clock edge, file[wb_fmode][wb_reg] <= wb_data.
- Write and read of the same register in the same cycle: governed by DECODE_BYPASS_EN.
- Back-to-back: with ex_stop=0 and no flush, one instruction per cycle at full throughput.

Optional Feature:
- Macro DECODE_BYPASS_EN.
- Defined: if wb_enable and (wb_fmode, wb_reg) matches a source's (file, number), that operand returns wb_data in the same cycle. Integer r0 is excluded and still reads 0.
- Undefined: the operand returns the old register value that cycle and the new value from the next cycle. Execute must tolerate this through ex_stop.

Test Plan:
- Reset with rstn low mid-stream -> ex_enable=0 immediately; after release, integer r29 reads 32'h0007_fffc and r30 reads 32'h0004_0000.
- Write int r5=32'h1234 then issue instr rs_no=5, opecode[4]=0 -> ex_rs=32'h1234. Write int r0=32'hffff -> r0 reads 0.
- Present instr 32'h0000_0000 at pc 8, hold ex_stop=1 for 3 cycles -> ex_enable=1 with ex_pc=8 all 3 cycles, in_ready=0. Release -> next instr presented the following cycle.
- ex_flush asserted while full with in_valid=1 -> next cycle ex_enable=0 and the incoming instr is not latched.
- wb_enable float f3=32'h3f80_0000 in the same cycle as a read of rt f3 (opecode[5]=1) -> 32'h3f80_0000 with DECODE_BYPASS_EN, old value without.
- Stream 4 instrs with in_valid=1 and ex_stop=0 -> ex_enable high 4 consecutive cycles; ex_pc sequence 0, 4, 8, 12.
